// File: rtl/fp_pkg.sv
// Shared FP32 constants and the fp_to_int32 state encoding for the NN datapath.
package fp_pkg;

    localparam int unsigned FP32_W    = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned E_W       = 10;
    localparam int unsigned CNT_W     = 5;

    localparam int unsigned FP32_BIAS    = 127;
    localparam int unsigned FP32_EXP_MAX = 255;

    localparam logic [FP32_W-1:0] INT32_MAX      = 32'h7FFF_FFFF;
    localparam logic [FP32_W-1:0] INT32_MIN      = 32'h8000_0000;
    localparam logic [FP32_W-1:0] FP32_CANON_NAN = 32'hFFC0_0000;
    localparam logic [FP32_W-1:0] FP32_NEG_2P31  = 32'hCF00_0000;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_UNPACK,
        ST_SPECIAL,
        ST_ALIGN,
        ST_ROUND,
        ST_PACK,
        ST_PUT_Z
    } state_t;

endpackage

// File: rtl/fp_to_int32.sv
// FP32 -> signed int32 converter, round-to-nearest-even with saturation.
// Iterative one-bit-per-cycle alignment behind stb/ack handshakes.
module fp_to_int32 #(
    parameter logic [31:0] SAT_NAN = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    import fp_pkg::*;

    state_t                   r_state, w_state;
    logic [FP32_W-1:0]        r_a, w_a;
    logic                     r_s, w_s;
    logic signed [E_W-1:0]    r_e, w_e;
    logic [FP32_W-1:0]        r_m, w_m;
    logic                     r_g, w_g;
    logic                     r_r, w_r;
    logic                     r_st, w_st;
    logic [CNT_W-1:0]         r_cnt, w_cnt;
    logic [FP32_W-1:0]        r_z, w_z;
    logic                     r_in_ack, w_in_ack;
    logic [FP32_W-1:0]        r_out_z, w_out_z;
    logic                     r_out_stb, w_out_stb;
    logic [FP32_W-1:0]        w_m_inc;
    logic [EXP_W-1:0]         w_exp;
    logic                     w_frac_nz;

    assign w_m_inc   = r_m + 32'd1;
    assign w_exp     = r_a[30:23];
    assign w_frac_nz = |r_a[FRAC_W-1:0];

    assign input_a_ack  = r_in_ack;
    assign output_z     = r_out_z;
    assign output_z_stb = r_out_stb;

    // Next-state and next-register values
    always_comb begin
        w_state   = r_state;
        w_a       = r_a;
        w_s       = r_s;
        w_e       = r_e;
        w_m       = r_m;
        w_g       = r_g;
        w_r       = r_r;
        w_st      = r_st;
        w_cnt     = r_cnt;
        w_z       = r_z;
        w_in_ack  = r_in_ack;
        w_out_z   = r_out_z;
        w_out_stb = r_out_stb;

        case (r_state)
            ST_GET_A: begin
                w_in_ack = 1'b1;
                if (r_in_ack && input_a_stb) begin
                    w_a      = input_a;
                    w_in_ack = 1'b0;
                    w_state  = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                w_s     = r_a[31];
                w_e     = $signed(E_W'(r_a[30:23]) - E_W'(FP32_BIAS));
                w_m     = {8'h00, 1'b1, r_a[FRAC_W-1:0]};
                w_g     = 1'b0;
                w_r     = 1'b0;
                w_st    = 1'b0;
                w_state = ST_SPECIAL;
            end
            ST_SPECIAL: begin
                w_state = ST_PUT_Z;
                if (w_exp == EXP_W'(FP32_EXP_MAX) && w_frac_nz) begin
                    w_z = SAT_NAN;
                end else if (w_exp == EXP_W'(FP32_EXP_MAX)) begin
                    w_z = r_s ? INT32_MIN : INT32_MAX;
                end else if (w_exp == '0) begin
                    w_z = '0;
                end else if (r_e < -10'sd1) begin
                    w_z = '0;
                end else if (r_a == FP32_NEG_2P31) begin
                    w_z = INT32_MIN;
                end else if (r_e >= 10'sd31) begin
                    w_z = r_s ? INT32_MIN : INT32_MAX;
                end else begin
                    w_cnt   = (r_e > 10'sd23) ? CNT_W'(r_e - 10'sd23) : CNT_W'(10'sd23 - r_e);
                    w_state = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                // Right shifts feed guard -> round -> sticky so the last shifted bit is the half bit
                if (r_cnt != '0) begin
                    if (r_e > 10'sd23) begin
                        w_m = {r_m[FP32_W-2:0], 1'b0};
                    end else begin
                        w_m  = {1'b0, r_m[FP32_W-1:1]};
                        w_g  = r_m[0];
                        w_r  = r_g;
                        w_st = r_st | r_r;
                    end
                    w_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (r_g && (r_r || r_st || r_m[0])) begin
                    w_m = (!r_s && w_m_inc[FP32_W-1]) ? INT32_MAX : w_m_inc;
                end
                w_state = ST_PACK;
            end
            ST_PACK: begin
                w_z     = r_s ? (~r_m + 32'd1) : r_m;
                w_state = ST_PUT_Z;
            end
            ST_PUT_Z: begin
                w_out_stb = 1'b1;
                w_out_z   = r_z;
                if (r_out_stb && output_z_ack) begin
                    w_out_stb = 1'b0;
                    w_state   = ST_GET_A;
                end
            end
            default: begin
                w_state = ST_GET_A;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_GET_A;
            r_a       <= '0;
            r_s       <= 1'b0;
            r_e       <= '0;
            r_m       <= '0;
            r_g       <= 1'b0;
            r_r       <= 1'b0;
            r_st      <= 1'b0;
            r_cnt     <= '0;
            r_z       <= '0;
            r_in_ack  <= 1'b0;
            r_out_z   <= '0;
            r_out_stb <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_a       <= w_a;
            r_s       <= w_s;
            r_e       <= w_e;
            r_m       <= w_m;
            r_g       <= w_g;
            r_r       <= w_r;
            r_st      <= w_st;
            r_cnt     <= w_cnt;
            r_z       <= w_z;
            r_in_ack  <= w_in_ack;
            r_out_z   <= w_out_z;
            r_out_stb <= w_out_stb;
        end
    end

endmodule

// File: tb/tb_fp_to_int32.sv
// Randomized bench for fp_to_int32: arithmetic reference model plus a negedge monitor
// that checks results, latency, handshakes and reset behaviour.
module tb_fp_to_int32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    localparam logic [31:0] TB_SAT_NAN = 32'h0000_0000;

    fp_to_int32 #(.SAT_NAN(TB_SAT_NAN)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Exact value = mant * 2^(exp-150); round half to even, then clamp to int32.
    function automatic logic [31:0] ref_conv(input logic [31:0] a);
        int     ex;
        int     n;
        longint mant, mag, q, rem, half, v;
        ex   = int'(a[30:23]);
        mant = 64'(a[22:0]) | 64'h80_0000;
        if (ex == 255 && a[22:0] != 0) return TB_SAT_NAN;
        if (ex == 255) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (ex == 0) return 32'h0;
        if (ex >= 150) begin
            if (ex - 150 > 8) mag = 64'sh10_0000_0000;
            else mag = mant << (ex - 150);
        end else begin
            n = 150 - ex;
            if (n >= 40) begin
                mag = 0;
            end else begin
                q    = mant >> n;
                rem  = mant - (q << n);
                half = 64'sd1 << (n - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                mag = q;
            end
        end
        v = a[31] ? -mag : mag;
        if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
        if (v < -64'sh8000_0000) v = -64'sh8000_0000;
        return 32'(v);
    endfunction

    function automatic int ref_lat(input logic [31:0] a);
        int e;
        e = int'(a[30:23]) - 127;
        if (a[30:23] == 8'hFF || a[30:23] == 8'h00 || e < -1 || a == 32'hCF00_0000 || e >= 31)
            return 4;
        return 7 + ((e > 23) ? (e - 23) : (23 - e));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] pin_a [13] = '{32'h3F80_0000, 32'h4020_0000, 32'h4060_0000, 32'hBFC0_0000,
                                32'h3F00_0000, 32'h3F40_0000, 32'h0000_0001, 32'hCF00_0000,
                                32'h5015_02F9, 32'hFF80_0000, 32'h7FC0_0000, 32'h40E0_0000,
                                32'h4120_0000};
    logic [31:0] pin_z [13] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'hFFFF_FFFE,
                                32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0007,
                                32'h0000_000A};

    // Monitor state
    logic        rst_q = 1'b1;
    int          cyc = 0;
    bit          pending = 1'b0;
    bit          seen_stb = 1'b0;
    bit          hs_d1 = 1'b0;
    bit          hs_d2 = 1'b0;
    int          lat = 0;
    int          exp_lat = 0;
    logic [31:0] exp_z = '0;
    int          n_done = 0;

    always @(posedge clk) rst_q <= rst;

    // Single compare process; inputs change only just after posedge
    always @(negedge clk) begin
        cyc++;
        if (cyc == 1) begin
            for (int i = 0; i < 13; i++) check($sformatf("model_%08h", pin_a[i]), ref_conv(pin_a[i]), pin_z[i]);
            check("model_lat_1p0", 32'(ref_lat(32'h3F80_0000)), 32'd30);
            check("model_lat_denorm", 32'(ref_lat(32'h0000_0001)), 32'd4);
        end
        if (rst_q) begin
            check("reset_z_stb", 32'(output_z_stb), 32'd0);
            check("reset_a_ack", 32'(input_a_ack), 32'd0);
            check("reset_z", output_z, 32'd0);
            pending = 1'b0;
            hs_d1   = 1'b0;
            hs_d2   = 1'b0;
        end else begin
            if (hs_d2) check("ack_return", 32'(input_a_ack), 32'd1);
            if (hs_d1) begin
                check("stb_drop", 32'(output_z_stb), 32'd0);
                check("ack_after_hs", 32'(input_a_ack), 32'd0);
            end
            if (pending) begin
                check("busy_ack", 32'(input_a_ack), 32'd0);
                if (!seen_stb) begin
                    lat++;
                    if (output_z_stb) begin
                        seen_stb = 1'b1;
                        check($sformatf("latency_%08h", dut.r_a), 32'(lat), 32'(exp_lat));
                    end else if (lat > 100) begin
                        check("latency_timeout", 32'(lat), 32'(exp_lat));
                        pending = 1'b0;
                    end
                end
                if (output_z_stb) check("output_z", output_z, exp_z);
            end
            hs_d2 = hs_d1;
            hs_d1 = output_z_stb && output_z_ack;
            if (hs_d1) begin
                pending = 1'b0;
                n_done++;
            end
            if (input_a_ack && input_a_stb) begin
                pending  = 1'b1;
                seen_stb = 1'b0;
                lat      = 0;
                exp_z    = ref_conv(input_a);
                exp_lat  = ref_lat(input_a);
            end
        end
    end

    task automatic send(input logic [31:0] a);
        @(posedge clk); #1;
        input_a     = a;
        input_a_stb = 1'b1;
        for (int i = 0; i <= 50; i++) begin
            if (i == 50) begin
                $display("FAIL accept_timeout: input_a_ack never rose for %08h", a);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
            if (input_a_ack) break;
        end
        @(posedge clk); #1;
        input_a_stb = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input int hold);
        send(a);
        for (int i = 0; i <= 60; i++) begin
            if (i == 60) begin
                $display("FAIL result_timeout: output_z_stb never rose for %08h", a);
                $fatal(1, "result timeout");
            end
            @(negedge clk);
            if (output_z_stb) break;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int          sel;
        sel = int'($urandom_range(0, 9));
        r   = $urandom;
        if (sel < 5) begin
            r[30:23] = 8'($urandom_range(120, 160));
        end else if (sel < 8) begin
            r[30:23] = 8'($urandom_range(126, 150));
            r[22:0]  = r[22:0] & 23'h7F_0000;
        end
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) run_op(pin_a[i], (pin_a[i] == 32'h40E0_0000) ? 10 : 0);

        // Reset while aligning 1.0, then convert 10.0
        send(32'h3F80_0000);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(32'h4120_0000, 0);

        for (int i = 0; i < 250; i++) run_op(rand_fp(), int'($urandom_range(0, 2)));

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
